planificador_alu: RTL and testbench
===================================

Name: planificador_alu

Overview:
- Round-robin arbiter and sequencer sharing one combinational 4-bit ALU (alu_controladora: AND/XOR/MULT/SUB with Z/N/C/V flags) between two requesters.
- Captures one operation per grant, registers the ALU result and flags, and presents them on a valid/ready result port tagged with the requester ID.
- Sits between the control units that issue ALU work and the shared ALU instance.

Parameters:
- PRIO_FIJA, 0, 0 = round-robin arbitration; 1 = fixed priority, requester 0 always wins ties.
- CNT_W, 8, width of the optional completed-operation counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in0_valid  in  1  requester 0 has an operation.
- in0_ready  out  1  requester 0 operation accepted this cycle.
- in0_A  in  2  requester 0 operand A.
- in0_B  in  4  requester 0 operand B.
- in0_op  in  2  requester 0 opcode (00 AND, 01 XOR, 10 MULT, 11 SUB).
- in1_valid, in1_ready, in1_A, in1_B, in1_op: same as requester 0, for requester 1.
- out_valid  out  1  result registered and available.
- out_ready  in  1  consumer accepts the result.
- out_id  out  1  requester that issued the result.
- out_Y  out  4  registered ALU result.
- out_Z, out_N, out_C, out_V  out  1 each  registered ALU flags.
- cnt0, cnt1  out  CNT_W each  completed operations per requester; present only with the macro.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; all output registers 0; out_valid=0; in0_ready=in1_ready=0.
  - Operand registers 0; last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation discards any captured operation or pending result; no partial output.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - The arbiter picks a winner among the valid requesters. One valid → that one. Both valid → the requester != last_grant if PRIO_FIJA=0; requester 0 if PRIO_FIJA=1.
  - inX_ready=1 combinationally only for the winner, and only in IDLE.
  - Transfer = inX_valid & inX_ready. On transfer: latch A, B, op and id into operand registers; last_grant <= id; go to EXEC.
  - No valid requester → stay in IDLE.
- EXEC:
  - The ALU sees only the operand registers, never the live inputs.
  - out_Y and the flags are registered from the ALU outputs; out_id <= captured id; out_valid <= 1; go to DONE.
- DONE:
  - out_* held stable while out_valid=1 and out_ready=0.
  - When out_ready=1: out_valid <= 0 and go to IDLE. Result fields keep their last value.
- Timing:
  - Transfer on cycle T → out_valid=1 from cycle T+2.
  - Earliest next transfer is in the cycle after the result handshake, so peak throughput is 1 operation per 3 cycles.
  - out_ready already high when out_valid rises → handshake on that first cycle; back to IDLE the next cycle.
- Both inX_ready are 0 in EXEC and DONE, so a requester that is not granted simply holds.
- Requesters must hold valid and operands stable until accepted. Dropping valid before acceptance is allowed and simply withdraws the request.
- All four opcodes are legal; there are no error states.

Optional Feature:
- Macro: PLANIFICADOR_CONTADOR_EN.
- Defined:
  - Ports cnt0 and cnt1 exist.
  - cntX increments by 1 on each result handshake (out_valid & out_ready) with out_id=X.
  - Counters wrap from 2^CNT_W-1 to 0 and reset to 0.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset and single SUB: in0 valid, A=2'b01, B=4'b0011, op=11, out_ready=1 → in0_ready=1 at T; out_valid=1 at T+2; out_id=0; out_Y=4'b1110, N=1; all flags equal the golden ALU model; in IDLE at T+3.
- Simultaneous requests, PRIO_FIJA=0, both valid continuously → grants alternate 0,1,0,1; out_id sequence 0,1,0,1.
- Same stimulus with PRIO_FIJA=1 → every grant goes to requester 0; in1_ready stays 0 while in0_valid=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_Y, flags and out_id stable; in0_ready=in1_ready=0; on out_ready=1, out_valid drops next cycle.
- Async reset asserted during EXEC, mid-cycle → out_valid=0 immediately; state IDLE; no result emitted; next tie is granted to requester 0.
- With PLANIFICADOR_CONTADOR_EN and CNT_W=2: 5 results from requester 1 → cnt1 = 0,1,2,3,0,1; cnt0 stays 0.

Source files
------------

// File: rtl/planificador_alu.sv
// Two-requester scheduler for one shared combinational 4-bit ALU, with a valid/ready result port.
// Optional per-requester completion counters are enabled with PLANIFICADOR_CONTADOR_EN.

module alu_controladora (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [3:0] y,
    output logic       z,
    output logic       n,
    output logic       c,
    output logic       v
);
    logic [7:0] prod;
    logic [4:0] diff;

    always_comb begin
        prod = a * b;
        diff = {1'b0, a} - {1'b0, b};
        y    = 4'd0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            2'b00: y = a & b;
            2'b01: y = a ^ b;
            // MULT keeps the low nibble; C flags any lost high bits.
            2'b10: begin
                y = prod[3:0];
                c = |prod[7:4];
            end
            default: begin
                y = diff[3:0];
                c = diff[4];
                v = (a[3] ^ b[3]) & (diff[3] ^ a[3]);
            end
        endcase
        z = (y == 4'd0);
        n = y[3];
    end
endmodule

module planificador_alu #(
    parameter int PRIO_FIJA = 0,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0_valid,
    output logic       in0_ready,
    input  logic [1:0] in0_A,
    input  logic [3:0] in0_B,
    input  logic [1:0] in0_op,
    input  logic       in1_valid,
    output logic       in1_ready,
    input  logic [1:0] in1_A,
    input  logic [3:0] in1_B,
    input  logic [1:0] in1_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic [3:0] out_Y,
    output logic       out_Z,
    output logic       out_N,
    output logic       out_C,
    output logic       out_V
`ifdef PLANIFICADOR_CONTADOR_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] a_q, a_d, op_q, op_d;
    logic [3:0] b_q, b_d, y_q, y_d;
    logic       id_q, id_d, last_q, last_d;
    logic       out_valid_q, out_valid_d, out_id_q, out_id_d;
    logic       z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic       grant1, xfer0, xfer1;
    logic [3:0] alu_y;
    logic       alu_z, alu_n, alu_c, alu_v;

    alu_controladora u_alu (
        .a  ({2'b00, a_q}),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y),
        .z  (alu_z),
        .n  (alu_n),
        .c  (alu_c),
        .v  (alu_v)
    );

    // Requester 1 wins only when alone, or on a round-robin tie after requester 0 was served.
    assign grant1    = in1_valid & (~in0_valid | ((PRIO_FIJA == 0) & ~last_q));
    assign in1_ready = (state_q == IDLE) & ~rst & grant1;
    assign in0_ready = (state_q == IDLE) & ~rst & in0_valid & ~grant1;
    assign xfer0     = in0_valid & in0_ready;
    assign xfer1     = in1_valid & in1_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        y_d         = y_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        case (state_q)
            IDLE: begin
                if (xfer0 | xfer1) begin
                    a_d     = xfer1 ? in1_A  : in0_A;
                    b_d     = xfer1 ? in1_B  : in0_B;
                    op_d    = xfer1 ? in1_op : in0_op;
                    id_d    = xfer1;
                    last_d  = xfer1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d         = alu_y;
                z_d         = alu_z;
                n_d         = alu_n;
                c_d         = alu_c;
                v_d         = alu_v;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            y_q         <= y_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_Y     = y_q;
    assign out_Z     = z_q;
    assign out_N     = n_q;
    assign out_C     = c_q;
    assign out_V     = v_q;

`ifdef PLANIFICADOR_CONTADOR_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             hs;

    assign hs = out_valid_q & out_ready;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (hs & ~out_id_q) cnt0_d = cnt0_q + 1'b1;
        if (hs & out_id_q)  cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_planificador_alu.sv
// Directed bench for planificador_alu: one round-robin and one fixed-priority instance on shared stimulus.
// Counter checks run only when PLANIFICADOR_CONTADOR_EN is defined.
`timescale 1ns/1ps

module tb_planificador_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] in0_A = '0, in1_A = '0, in0_op = '0, in1_op = '0;
    logic [3:0] in0_B = '0, in1_B = '0;

    logic       rr_in0_ready, rr_in1_ready, rr_out_valid, rr_out_id;
    logic [3:0] rr_out_Y;
    logic       rr_Z, rr_N, rr_C, rr_V;
    logic       fp_in0_ready, fp_in1_ready, fp_out_valid, fp_out_id;
    logic [3:0] fp_out_Y;
    logic       fp_Z, fp_N, fp_C, fp_V;
`ifdef PLANIFICADOR_CONTADOR_EN
    logic [1:0] rr_cnt0, rr_cnt1, fp_cnt0, fp_cnt1;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    planificador_alu #(.PRIO_FIJA(0), .CNT_W(2)) u_rr (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(rr_in0_ready), .in0_A(in0_A), .in0_B(in0_B), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_ready(rr_in1_ready), .in1_A(in1_A), .in1_B(in1_B), .in1_op(in1_op),
        .out_valid(rr_out_valid), .out_ready(out_ready), .out_id(rr_out_id), .out_Y(rr_out_Y),
        .out_Z(rr_Z), .out_N(rr_N), .out_C(rr_C), .out_V(rr_V)
`ifdef PLANIFICADOR_CONTADOR_EN
        , .cnt0(rr_cnt0), .cnt1(rr_cnt1)
`endif
    );

    planificador_alu #(.PRIO_FIJA(1), .CNT_W(2)) u_fp (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(fp_in0_ready), .in0_A(in0_A), .in0_B(in0_B), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_ready(fp_in1_ready), .in1_A(in1_A), .in1_B(in1_B), .in1_op(in1_op),
        .out_valid(fp_out_valid), .out_ready(out_ready), .out_id(fp_out_id), .out_Y(fp_out_Y),
        .out_Z(fp_Z), .out_N(fp_N), .out_C(fp_C), .out_V(fp_V)
`ifdef PLANIFICADOR_CONTADOR_EN
        , .cnt0(fp_cnt0), .cnt1(fp_cnt1)
`endif
    );

    // Golden ALU in integer arithmetic: returns {Y, Z, N, C, V}.
    function automatic logic [7:0] alu_model(input int a, input int b, input int op);
        int r, sb, sr;
        logic [3:0] y;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a ^ b;
            2: begin r = a * b; c = (r > 15); end
            default: begin
                r  = a - b;
                c  = (a < b);
                sb = (b > 7) ? b - 16 : b;
                sr = a - sb;
                v  = (sr > 7) || (sr < -8);
            end
        endcase
        y = 4'(r & 15);
        return {y, (y == 4'd0), y[3], c, v};
    endfunction

    task automatic do_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        #3;
        tests_run++;
        if ({rr_out_valid, rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V, rr_in0_ready, rr_in1_ready} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 000000000000",
                     {rr_out_valid, rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V, rr_in0_ready, rr_in1_ready});
        end
        do_reset();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_sub();
        logic [7:0] exp;
        do_reset();
        exp = alu_model(1, 3, 3);
        in0_valid = 1'b1; in0_A = 2'b01; in0_B = 4'b0011; in0_op = 2'b11; out_ready = 1'b1;
        #1;
        tests_run++;
        if (rr_in0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_in0_ready_T: got %b expected 1", rr_in0_ready);
        end
        @(posedge clk); #1 in0_valid = 1'b0; #1;
        tests_run++;
        if (rr_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_valid_T1: got %b expected 0", rr_out_valid);
        end
        @(posedge clk); #2;
        tests_run++;
        if ({rr_out_valid, rr_out_id, rr_out_Y, rr_N} !== {1'b1, 1'b0, 4'b1110, 1'b1}) begin
            tests_failed++;
            $display("FAIL sub_result_T2: got valid=%b id=%b Y=%b N=%b expected valid=1 id=0 Y=1110 N=1",
                     rr_out_valid, rr_out_id, rr_out_Y, rr_N);
        end
        tests_run++;
        if ({rr_out_Y, rr_Z, rr_N, rr_C, rr_V} !== exp) begin
            tests_failed++;
            $display("FAIL sub_flags: got %b expected %b", {rr_out_Y, rr_Z, rr_N, rr_C, rr_V}, exp);
        end
        @(posedge clk); #1 in0_valid = 1'b1; #1;
        tests_run++;
        if ({rr_out_valid, rr_in0_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL sub_idle_T3: got valid/ready=%b expected 01", {rr_out_valid, rr_in0_ready});
        end
        in0_valid = 1'b0;
        $display("[TB] test_single_sub done: Y=%b flags=%b", rr_out_Y, {rr_Z, rr_N, rr_C, rr_V});
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp0, exp1;
        logic [3:0] rr_ids, fp_ids;
        int nrr, nfp;
        do_reset();
        exp0 = alu_model(2, 6, 1);
        exp1 = alu_model(3, 9, 0);
        nrr = 0; nfp = 0; rr_ids = '0; fp_ids = '0;
        in0_A = 2'd2; in0_B = 4'd6; in0_op = 2'b01;
        in1_A = 2'd3; in1_B = 4'd9; in1_op = 2'b00;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 30 && (nrr < 4 || nfp < 4); k++) begin
            @(posedge clk); #2;
            tests_run++;
            if (fp_in1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL fixed_in1_ready: got %b expected 0 at cycle %0d", fp_in1_ready, k);
            end
            if (rr_out_valid && nrr < 4) begin
                rr_ids[nrr] = rr_out_id;
                tests_run++;
                if ({rr_out_Y, rr_Z, rr_N, rr_C, rr_V} !== (rr_out_id ? exp1 : exp0)) begin
                    tests_failed++;
                    $display("FAIL rr_result_%0d: got %b expected %b", nrr,
                             {rr_out_Y, rr_Z, rr_N, rr_C, rr_V}, rr_out_id ? exp1 : exp0);
                end
                $display("[TB] rr result %0d id=%0d Y=%b", nrr, rr_out_id, rr_out_Y);
                nrr++;
            end
            if (fp_out_valid && nfp < 4) begin
                fp_ids[nfp] = fp_out_id;
                $display("[TB] fixed result %0d id=%0d Y=%b", nfp, fp_out_id, fp_out_Y);
                nfp++;
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        tests_run++;
        if (nrr != 4 || rr_ids !== 4'b1010) begin
            tests_failed++;
            $display("FAIL rr_id_sequence: got %0d results ids(LSB first)=%b expected 4 results 1010", nrr, rr_ids);
        end
        tests_run++;
        if (nfp != 4 || fp_ids !== 4'b0000) begin
            tests_failed++;
            $display("FAIL fixed_id_sequence: got %0d results ids=%b expected 4 results 0000", nfp, fp_ids);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        logic [8:0] held;
        do_reset();
        exp = alu_model(3, 6, 2);
        in1_valid = 1'b1; in1_A = 2'd3; in1_B = 4'd6; in1_op = 2'b10; out_ready = 1'b0;
        #1;
        tests_run++;
        if (rr_in1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_in1_ready: got %b expected 1", rr_in1_ready);
        end
        @(posedge clk); #1 in1_valid = 1'b0; #1;
        for (int k = 0; k < 6 && !rr_out_valid; k++) begin
            @(posedge clk); #2;
        end
        tests_run++;
        if (rr_out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_timeout: out_valid=%b expected 1 within 6 cycles", rr_out_valid);
        end
        tests_run++;
        if ({rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V} !== {1'b1, exp}) begin
            tests_failed++;
            $display("FAIL bp_result: got %b expected %b", {rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V}, {1'b1, exp});
        end
        held = {rr_out_id, exp};
        in0_valid = 1'b1; in1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            tests_run++;
            if ({rr_out_valid, rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V, rr_in0_ready, rr_in1_ready} !==
                {1'b1, held, 2'b00}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got %b expected %b", k,
                         {rr_out_valid, rr_out_id, rr_out_Y, rr_Z, rr_N, rr_C, rr_V, rr_in0_ready, rr_in1_ready},
                         {1'b1, held, 2'b00});
            end
        end
        out_ready = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        @(posedge clk); #2;
        tests_run++;
        if (rr_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got out_valid=%b expected 0", rr_out_valid);
        end
        $display("[TB] test_backpressure done: held Y=%b id=%0d", held[7:4], held[8]);
    endtask

    task automatic test_async_reset();
        do_reset();
        in0_A = 2'd1; in0_B = 4'd1; in0_op = 2'b00;
        in1_A = 2'd2; in1_B = 4'd3; in1_op = 2'b01;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        // Serve one tie (goes to 0) so last_grant=0 before the reset.
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        tests_run++;
        if (rr_in1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_second_tie: got in1_ready=%b expected 1", rr_in1_ready);
        end
        @(posedge clk); #1 in0_valid = 1'b0; in1_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if ({rr_out_valid, rr_in0_ready, rr_in1_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ar_immediate: got %b expected 000", {rr_out_valid, rr_in0_ready, rr_in1_ready});
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            tests_run++;
            if (rr_out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL ar_no_result_%0d: got out_valid=%b expected 0", k, rr_out_valid);
            end
        end
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        tests_run++;
        if ({rr_in0_ready, rr_in1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL ar_tie_after_reset: got ready=%b expected 10", {rr_in0_ready, rr_in1_ready});
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        $display("[TB] test_async_reset done");
    endtask

`ifdef PLANIFICADOR_CONTADOR_EN
    task automatic test_counter();
        do_reset();
        in1_A = 2'd1; in1_B = 4'd2; in1_op = 2'b01;
        in1_valid = 1'b1; out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6 && !rr_out_valid; k++) begin
                @(posedge clk); #2;
            end
            tests_run++;
            if ({rr_out_valid, rr_cnt1, rr_cnt0} !== {1'b1, 2'(r % 4), 2'd0}) begin
                tests_failed++;
                $display("FAIL cnt_result_%0d: got valid=%b cnt1=%0d cnt0=%0d expected valid=1 cnt1=%0d cnt0=0",
                         r, rr_out_valid, rr_cnt1, rr_cnt0, r % 4);
            end
            $display("[TB] counter result %0d cnt1=%0d", r, rr_cnt1);
            @(posedge clk); #2;
        end
        in1_valid = 1'b0;
        tests_run++;
        if ({rr_cnt1, rr_cnt0} !== {2'd1, 2'd0}) begin
            tests_failed++;
            $display("FAIL cnt_final: got cnt1=%0d cnt0=%0d expected cnt1=1 cnt0=0", rr_cnt1, rr_cnt0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_sub();
        test_simultaneous();
        test_backpressure();
        test_async_reset();
`ifdef PLANIFICADOR_CONTADOR_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end
endmodule
